// File: rtl/sat_pkg.sv
// Shared constants, record layout and FSM state encoding for the satellite packet assembler.
package sat_pkg;
   localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
   localparam int         PKT_DATA_BYTES = 16;
   localparam int         ID_W           = 5;
   localparam int         FIELD_W        = 32;
   localparam int         REC_W          = 128;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_ID,
      ST_DATA,
      ST_CSUM,
      ST_WRITE
   } sat_state_e;

   typedef struct packed {
      logic [FIELD_W-1:0] tim;
      logic [FIELD_W-1:0] xpos;
      logic [FIELD_W-1:0] ypos;
      logic [FIELD_W-1:0] zpos;
   } sat_rec_t;
endpackage

// File: rtl/sat_gap_timer.sv
// Inter-byte gap timer: a down-counter reloaded by clear.
// expired flags the edge on which the idle count would reach TIMEOUT.
module sat_gap_timer #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int             CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = LOAD;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // a byte on the same edge clears the timer, so it always beats the abort
   assign expired = enable && !clear && (cnt_q == '0);
endmodule

// File: rtl/sat_packet_assembler.sv
// Assembles SYNC/ID/16-data/CSUM byte packets into satellite records and
// issues a one-cycle RAM write strobe for each packet with a valid checksum.
//
// state    | meaning
// ST_HUNT  | waiting for SYNC
// ST_ID    | expecting ID byte
// ST_DATA  | collecting 16 data bytes
// ST_CSUM  | expecting checksum byte
// ST_WRITE | one-cycle write strobe, evaluates input as HUNT
module sat_packet_assembler
   import sat_pkg::*;
#(
   parameter int         TIMEOUT = 1000,
   parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         din,
   input  logic               din_valid,
   output logic               rnw,
   output logic [ID_W-1:0]    wa,
   output logic [FIELD_W-1:0] tim,
   output logic [FIELD_W-1:0] xpos,
   output logic [FIELD_W-1:0] ypos,
   output logic [FIELD_W-1:0] zpos,
   output logic               busy,
   output logic [7:0]         err_count
);
   localparam logic [3:0] LAST_BYTE = 4'(PKT_DATA_BYTES - 1);

   sat_state_e       state_q, state_d;
   logic [3:0]       byte_cnt_q, byte_cnt_d;
   logic [7:0]       csum_q, csum_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [REC_W-1:0] shift_q, shift_d;
   logic [ID_W-1:0]  wa_q, wa_d;
   sat_rec_t         rec_q, rec_d;
   logic [7:0]       err_q, err_d;
   logic             pkt_err;
   logic             gap_en, gap_expired;

   assign gap_en = (state_q == ST_ID) || (state_q == ST_DATA) || (state_q == ST_CSUM);

   sat_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (din_valid || !gap_en),
      .enable  (gap_en),
      .expired (gap_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pkt_err = 1'b0;
      unique case (state_q)
         ST_HUNT, ST_WRITE: begin
            state_d = (din_valid && (din == SYNC)) ? ST_ID : ST_HUNT;
         end
         ST_ID: begin
            if (din_valid) begin
               if (din[7:5] == 3'b000) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_HUNT;
                  pkt_err = 1'b1;
               end
            end else if (gap_expired) begin
               state_d = ST_HUNT;
               pkt_err = 1'b1;
            end
         end
         ST_DATA: begin
            if (din_valid) begin
               if (byte_cnt_q == LAST_BYTE) state_d = ST_CSUM;
            end else if (gap_expired) begin
               state_d = ST_HUNT;
               pkt_err = 1'b1;
            end
         end
         ST_CSUM: begin
            if (din_valid) begin
               if (din == csum_q) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_HUNT;
                  pkt_err = 1'b1;
               end
            end else if (gap_expired) begin
               state_d = ST_HUNT;
               pkt_err = 1'b1;
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   always_comb begin
      rnw  = (state_q == ST_WRITE);
      busy = (state_q != ST_HUNT);
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      csum_d     = csum_q;
      id_d       = id_q;
      shift_d    = shift_q;
      wa_d       = wa_q;
      rec_d      = rec_q;
      err_d      = err_q;
      if ((state_q == ST_ID) && din_valid) begin
         byte_cnt_d = '0;
         csum_d     = din;
         id_d       = din[ID_W-1:0];
      end
      if ((state_q == ST_DATA) && din_valid) begin
         byte_cnt_d = byte_cnt_q + 4'd1;
         csum_d     = csum_q ^ din;
         shift_d    = {shift_q[REC_W-9:0], din};
      end
      // published fields only move when a checked packet commits
      if ((state_q == ST_CSUM) && (state_d == ST_WRITE)) begin
         wa_d  = id_q;
         rec_d = sat_rec_t'(shift_q);
      end
      if (pkt_err && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= '0;
         csum_q     <= '0;
         id_q       <= '0;
         shift_q    <= '0;
         wa_q       <= '0;
         rec_q      <= '0;
         err_q      <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         csum_q     <= csum_d;
         id_q       <= id_d;
         shift_q    <= shift_d;
         wa_q       <= wa_d;
         rec_q      <= rec_d;
         err_q      <= err_d;
      end
   end

   assign wa        = wa_q;
   assign tim       = rec_q.tim;
   assign xpos      = rec_q.xpos;
   assign ypos      = rec_q.ypos;
   assign zpos      = rec_q.zpos;
   assign err_count = err_q;
endmodule

// File: tb/tb_sat_packet_assembler.sv
// Bench for sat_packet_assembler: a packet-level queue model checked every cycle,
// a table of packet vectors, hand-written corner sequences and random traffic.
module tb_sat_packet_assembler;
   localparam int         TO = 8;
   localparam logic [7:0] SY = 8'hA5;

   logic        clk = 1'b0;
   logic        rst, din_valid;
   logic [7:0]  din;
   logic        rnw, busy;
   logic [4:0]  wa;
   logic [31:0] tim, xpos, ypos, zpos;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   sat_packet_assembler #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .rnw(rnw), .wa(wa), .tim(tim), .xpos(xpos), .ypos(ypos), .zpos(zpos),
      .busy(busy), .err_count(err_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: bytes of the packet under construction kept in a queue
   logic [7:0]  q[$];
   int          idle = 0;
   logic        m_rnw = 1'b0, m_busy = 1'b0;
   logic [4:0]  m_wa = '0;
   logic [31:0] m_f[4] = '{default: 32'h0};
   int          m_err = 0;

   task automatic m_bump();
      if (m_err < 255) m_err++;
   endtask

   task automatic model_step(input bit r, input bit v, input logic [7:0] b);
      logic [7:0] x;
      m_rnw = 1'b0;
      if (r) begin
         q.delete();
         idle = 0;
         m_wa = '0;
         for (int k = 0; k < 4; k++) m_f[k] = '0;
         m_err = 0;
      end else if (v) begin
         idle = 0;
         if (q.size() == 0) begin
            if (b == SY) q.push_back(b);
         end else begin
            q.push_back(b);
            if (q.size() == 2 && b[7:5] != 3'b000) begin
               q.delete();
               m_bump();
            end else if (q.size() == 19) begin
               x = 8'h00;
               for (int i = 1; i < 18; i++) x ^= q[i];
               if (x == q[18]) begin
                  m_rnw = 1'b1;
                  m_wa  = q[1][4:0];
                  for (int k = 0; k < 4; k++)
                     for (int j = 0; j < 4; j++) m_f[k] = {m_f[k][23:0], q[2 + 4*k + j]};
               end else begin
                  m_bump();
               end
               q.delete();
            end
         end
      end else if (q.size() != 0) begin
         idle++;
         if (idle >= TO) begin
            q.delete();
            idle = 0;
            m_bump();
         end
      end
      m_busy = (q.size() != 0) || m_rnw;
   endtask

   int          pulses = 0;
   logic [31:0] tim_log[4];

   task automatic cyc(input bit r, input bit v, input logic [7:0] b);
      rst = r; din_valid = v; din = b;
      @(posedge clk);
      model_step(r, v, b);
      #1;
      check("rnw",  32'(rnw),       32'(m_rnw));
      check("busy", 32'(busy),      32'(m_busy));
      check("err",  32'(err_count), 32'(m_err));
      check("wa",   32'(wa),        32'(m_wa));
      check("tim",  tim,  m_f[0]);
      check("xpos", xpos, m_f[1]);
      check("ypos", ypos, m_f[2]);
      check("zpos", zpos, m_f[3]);
      if (rnw === 1'b1) begin
         if (pulses < 4) tim_log[pulses] = tim;
         pulses++;
      end
      @(negedge clk);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   logic [7:0] pk[19];

   task automatic build(input logic [7:0] id, input logic [31:0] t, x, y, z, input logic [7:0] cbad);
      logic [31:0] f[4];
      logic [7:0]  c;
      f = '{t, x, y, z};
      pk[0] = SY;
      pk[1] = id;
      c = id;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) begin
            pk[2 + 4*k + j] = f[k][31 - 8*j -: 8];
            c ^= pk[2 + 4*k + j];
         end
      pk[18] = c ^ cbad;
   endtask

   task automatic send_pkt(input logic [7:0] id, input logic [31:0] t, x, y, z, input logic [7:0] cbad);
      build(id, t, x, y, z, cbad);
      for (int i = 0; i < 19; i++) cyc(1'b0, 1'b1, pk[i]);
   endtask

   typedef struct {
      logic [7:0]  id;
      logic [31:0] t, x, y, z;
      logic [7:0]  cbad;
      int          exp_pulses;
      logic [4:0]  exp_wa;
      logic [31:0] exp_tim, exp_zpos;
      logic [7:0]  exp_err;
   } vec_t;

   vec_t vt[5];

   initial begin
      vt[0] = '{8'h03, 32'h10, 32'h20, 32'h30, 32'h40, 8'h00, 1, 5'd3,  32'h10, 32'h40, 8'd0};
      vt[1] = '{8'h03, 32'h10, 32'h20, 32'h30, 32'h40, 8'h07, 0, 5'd3,  32'h10, 32'h40, 8'd1};
      vt[2] = '{8'h25, 32'h10, 32'h20, 32'h30, 32'h40, 8'h00, 0, 5'd3,  32'h10, 32'h40, 8'd2};
      vt[3] = '{8'h1F, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 8'h00,
                1, 5'd31, 32'h11223344, 32'hDDEEFF00, 8'd2};
      vt[4] = '{8'h05, 32'hA5A5A5A5, 32'hA5000001, 32'h12345678, 32'h00A50000, 8'h00,
                1, 5'd5, 32'hA5A5A5A5, 32'h00A50000, 8'd2};

      rst = 1'b1; din_valid = 1'b0; din = 8'h00;
      @(negedge clk);
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b1, SY);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_err",  32'(err_count), 32'd0);
      check("reset_tim",  tim, 32'd0);
      idle_n(1);

      // table-driven packets
      for (int n = 0; n < 5; n++) begin
         pulses = 0;
         send_pkt(vt[n].id, vt[n].t, vt[n].x, vt[n].y, vt[n].z, vt[n].cbad);
         idle_n(2);
         check($sformatf("vec%0d_pulses", n), 32'(pulses), 32'(vt[n].exp_pulses));
         check($sformatf("vec%0d_wa", n),     32'(wa), 32'(vt[n].exp_wa));
         check($sformatf("vec%0d_tim", n),    tim, vt[n].exp_tim);
         check($sformatf("vec%0d_zpos", n),   zpos, vt[n].exp_zpos);
         check($sformatf("vec%0d_err", n),    32'(err_count), 32'(vt[n].exp_err));
      end

      // bad ID drops straight back to HUNT
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, SY);
      cyc(1'b0, 1'b1, 8'h25);
      check("badid_busy", 32'(busy), 32'd0);
      check("badid_err",  32'(err_count), 32'd1);

      // timeout after 5 data bytes: 7 idle cycles keep the packet, the 8th aborts
      cyc(1'b1, 1'b0, 8'h00);
      build(8'h02, 32'hCAFE0001, 32'h2, 32'h3, 32'h4, 8'h00);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, pk[i]);
      idle_n(7);
      check("to7_busy", 32'(busy), 32'd1);
      idle_n(1);
      check("to8_busy", 32'(busy), 32'd0);
      check("to8_err",  32'(err_count), 32'd1);

      // byte arriving on the 8th idle edge wins
      pulses = 0;
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, pk[i]);
      idle_n(7);
      cyc(1'b0, 1'b1, pk[7]);
      check("to_race_busy", 32'(busy), 32'd1);
      check("to_race_err",  32'(err_count), 32'd1);
      for (int i = 8; i < 19; i++) cyc(1'b0, 1'b1, pk[i]);
      idle_n(1);
      check("to_race_pulse", 32'(pulses), 32'd1);
      check("to_race_tim",   tim, 32'hCAFE0001);

      // reset on the 10th data byte discards the packet and clears err_count
      build(8'h09, 32'h0BAD0BAD, 32'h1, 32'h2, 32'h3, 8'h00);
      pulses = 0;
      for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, pk[i]);
      cyc(1'b1, 1'b1, pk[11]);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_err",  32'(err_count), 32'd0);
      check("rstmid_wa",   32'(wa), 32'd0);
      check("rstmid_tim",  tim, 32'd0);
      send_pkt(8'h0A, 32'h600DF00D, 32'h7, 32'h8, 32'h9, 8'h00);
      idle_n(1);
      check("rstmid_pulses", 32'(pulses), 32'd1);
      check("rstmid_next_wa", 32'(wa), 32'd10);

      // back-to-back packets: next SYNC lands in the WRITE cycle
      pulses = 0;
      send_pkt(8'h01, 32'hAAAA0001, 32'h00A50000, 32'h3, 32'h4, 8'h00);
      send_pkt(8'h02, 32'hBBBB0002, 32'h5, 32'h6, 32'hA5A5A5A5, 8'h00);
      idle_n(2);
      check("b2b_pulses", 32'(pulses), 32'd2);
      check("b2b_tim0",   tim_log[0], 32'hAAAA0001);
      check("b2b_tim1",   tim_log[1], 32'hBBBB0002);
      check("b2b_zpos",   zpos, 32'hA5A5A5A5);

      // err_count saturation
      for (int i = 0; i < 260; i++) begin
         cyc(1'b0, 1'b1, SY);
         cyc(1'b0, 1'b1, 8'hE0);
      end
      check("err_sat", 32'(err_count), 32'd255);

      // random traffic against the model
      cyc(1'b1, 1'b0, 8'h00);
      for (int p = 0; p < 300; p++) begin
         logic [7:0] id, cb;
         if ($urandom_range(99) < 2) cyc(1'b1, 1'b0, 8'h00);
         idle_n(int'($urandom_range(3)));
         if ($urandom_range(9) == 0) cyc(1'b0, 1'b1, 8'($urandom));
         id = ($urandom_range(9) == 0) ? 8'($urandom) : {3'b000, 5'($urandom)};
         cb = ($urandom_range(99) < 15) ? 8'($urandom_range(255, 1)) : 8'h00;
         build(id, $urandom, $urandom, $urandom, $urandom, cb);
         for (int i = 0; i < 19; i++) begin
            if ($urandom_range(19) == 0) idle_n(int'($urandom_range(TO + 2, 1)));
            cyc(1'b0, 1'b1, pk[i]);
         end
      end
      idle_n(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
